// File: rtl/bsh_pkg.sv
// Shared types for the pipelined barrel shifter: operation modes and a mode-legality helper.
package bsh_pkg;

  typedef enum logic [2:0] {
    BSH_ROR = 3'd0,
    BSH_ROL = 3'd1,
    BSH_LSR = 3'd2,
    BSH_LSL = 3'd3,
    BSH_ASR = 3'd4
  } bsh_mode_e;

  // Codes 5..7 are reserved and pass the operand through untouched.
  function automatic logic is_valid_mode(bsh_mode_e mode);
    return mode inside {BSH_ROR, BSH_ROL, BSH_LSR, BSH_LSL, BSH_ASR};
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One pipeline rank of the barrel shifter: conditional move by SHIFT, then a register with
// a valid bit. Loads whenever the ready chain grants it (load_i).
module bsh_stage
  import bsh_pkg::*;
#(
  parameter int unsigned LOG2W = 3,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 valid_i,
  input  logic [(1<<LOG2W)-1:0] data_i,
  input  logic [LOG2W-1:0]     amt_i,
  input  logic [2:0]           mode_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  output logic [(1<<LOG2W)-1:0] data_o,
  output logic [LOG2W-1:0]     amt_o,
  output logic [2:0]           mode_o,
  output logic [TAG_W-1:0]     tag_o
);

  localparam int unsigned W   = 1 << LOG2W;
  localparam int unsigned Bit = $clog2(SHIFT);

  logic             valid_q;
  logic [W-1:0]     data_d, data_q;
  logic [LOG2W-1:0] amt_q;
  logic [2:0]       mode_q;
  logic [TAG_W-1:0] tag_q;

  always_comb begin
    data_d = data_i;
    if (amt_i[Bit] && is_valid_mode(bsh_mode_e'(mode_i))) begin
      case (bsh_mode_e'(mode_i))
        BSH_ROR: data_d = {data_i[SHIFT-1:0], data_i[W-1:SHIFT]};
        BSH_ROL: data_d = {data_i[W-SHIFT-1:0], data_i[W-1:W-SHIFT]};
        BSH_LSR: data_d = data_i >> SHIFT;
        BSH_LSL: data_d = data_i << SHIFT;
        BSH_ASR: data_d = $signed(data_i) >>> SHIFT;
        default: data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
    end
  end

  // Payload needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_d;
      amt_q  <= amt_i;
      mode_q <= mode_i;
      tag_q  <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter with valid/ready on both sides, one rank per log2 stage.
// Optional carry output enabled by defining BSH_CARRY_EN.
module pipelined_barrel_shifter
  import bsh_pkg::*;
#(
  parameter int unsigned LOG2W = 3,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [(1<<LOG2W)-1:0]   in_data,
  input  logic [LOG2W-1:0]        in_amt,
  input  logic [2:0]              in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<LOG2W)-1:0]   out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_carry
);

  localparam int unsigned W = 1 << LOG2W;

  // Index 0 is the input port; index i+1 is the register of stage i.
  logic [W-1:0]     stg_data [LOG2W+1];
  logic [LOG2W-1:0] stg_amt  [LOG2W+1];
  logic [2:0]       stg_mode [LOG2W+1];
  logic [TAG_W-1:0] stg_tag  [LOG2W+1];
  logic             stg_v    [LOG2W+1];
  logic [LOG2W:0]   rdy;

  assign stg_v[0]    = in_valid;
  assign stg_data[0] = in_data;
  assign stg_amt[0]  = in_amt;
  assign stg_mode[0] = in_mode;
  assign stg_tag[0]  = in_tag;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    rdy[LOG2W] = out_ready;
    for (int i = LOG2W - 1; i >= 0; i--) begin
      rdy[i] = !stg_v[i+1] || rdy[i+1];
    end
  end

  for (genvar i = 0; i < LOG2W; i++) begin : g_stage
    bsh_stage #(
      .LOG2W(LOG2W),
      .TAG_W(TAG_W),
      .SHIFT(1 << i)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .load_i (rdy[i]),
      .valid_i(stg_v[i]),
      .data_i (stg_data[i]),
      .amt_i  (stg_amt[i]),
      .mode_i (stg_mode[i]),
      .tag_i  (stg_tag[i]),
      .valid_o(stg_v[i+1]),
      .data_o (stg_data[i+1]),
      .amt_o  (stg_amt[i+1]),
      .mode_o (stg_mode[i+1]),
      .tag_o  (stg_tag[i+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg_v[LOG2W];
  assign out_data  = stg_data[LOG2W];
  assign out_tag   = stg_tag[LOG2W];

  logic unused_stage_tail;
  assign unused_stage_tail = ^{stg_amt[LOG2W], stg_mode[LOG2W]};

`ifdef BSH_CARRY_EN
  logic carry_in [LOG2W];
  logic carry_d  [LOG2W];
  logic carry_q  [LOG2W];

  // The last stage that actually moves the word records the final bit shifted out.
  for (genvar i = 0; i < LOG2W; i++) begin : g_carry
    localparam int unsigned Shift = 1 << i;
    logic moves, low_side;
    if (i == 0) begin : g_first
      assign carry_in[i] = 1'b0;
    end else begin : g_rest
      assign carry_in[i] = carry_q[i-1];
    end
    assign moves    = stg_amt[i][i] && is_valid_mode(bsh_mode_e'(stg_mode[i]));
    assign low_side = (stg_mode[i] == BSH_ROR) || (stg_mode[i] == BSH_LSR) ||
                      (stg_mode[i] == BSH_ASR);
    assign carry_d[i] = !moves   ? carry_in[i] :
                        low_side ? stg_data[i][Shift-1] : stg_data[i][W-Shift];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LOG2W; i++) begin
      if (reset) begin
        carry_q[i] <= 1'b0;
      end else if (rdy[i]) begin
        carry_q[i] <= carry_d[i];
      end
    end
  end

  assign out_carry = carry_q[LOG2W-1];
`else
  assign out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed vectors, random streaming with
// random backpressure, stall fill/drain and mid-stream reset.
module tb_pipelined_barrel_shifter;

  localparam int unsigned LOG2W = 3;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned W     = 1 << LOG2W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [LOG2W-1:0] in_amt = '0;
  logic [2:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_carry;

  pipelined_barrel_shifter #(.LOG2W(LOG2W), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     d;
    logic [TAG_W-1:0] t;
    logic             c;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    int           k;
    logic [2:0]   m;
    logic [W-1:0] y;
    logic         c;
  } dvec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: rotates via a doubled word, shifts via plain operators.
  function automatic void ref_model(input logic [W-1:0] a, input int k, input logic [2:0] m,
                                    output logic [W-1:0] y, output logic c);
    logic [2*W-1:0] dbl;
    dbl = {a, a};
    y = a;
    c = 1'b0;
    if (k != 0 && m <= 3'd4) begin
      case (m)
        3'd0: begin dbl = dbl >> k; y = dbl[W-1:0];   c = y[W-1];  end
        3'd1: begin dbl = dbl << k; y = dbl[2*W-1:W]; c = y[0];    end
        3'd2: begin y = a >> k;                       c = a[k-1];  end
        3'd3: begin y = a << k;                       c = a[W-k];  end
        default: begin y = W'($signed(a) >>> k);      c = a[k-1];  end
      endcase
    end
`ifndef BSH_CARRY_EN
    c = 1'b0;
`endif
  endfunction

  // Presents a word from posedge+1 and waits (bounded) for acceptance; leaves in_valid high.
  task automatic send_word(input logic [W-1:0] a, input int k, input logic [2:0] m,
                           input logic [TAG_W-1:0] t, input logic [W-1:0] ey, input logic ec,
                           input bit push);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = a;
    in_amt   = LOG2W'(k);
    in_mode  = m;
    in_tag   = t;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back('{d: ey, t: t, c: ec});
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] t, input bit push);
    logic [W-1:0] a, y;
    int           k;
    logic [2:0]   m;
    logic         c;
    a = W'($urandom);
    k = int'($urandom_range(0, W - 1));
    m = 3'($urandom_range(0, 7));
    ref_model(a, k, m, y, c);
    send_word(a, k, m, t, y, c, push);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom);
    end
  end

  // Monitor: pops on every output transfer and checks hold-while-stalled.
  bit               was_stalled = 1'b0;
  logic [W+TAG_W:0] held;
  always @(negedge clk) begin
    if (reset) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_payload", 32'({out_data, out_tag, out_carry}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_tag", 32'(out_tag), 32'(e.t));
          chk("out_carry", 32'(out_carry), 32'(e.c));
        end
      end
      was_stalled = out_valid && !out_ready;
      held = {out_data, out_tag, out_carry};
    end
  end

  dvec_t dir [13];
  int    lat;
  int    acc;
  int    cnt;

  initial begin
    dir = '{
      '{8'h96, 3, 3'd0, 8'hD2, 1'b1},
      '{8'h96, 1, 3'd1, 8'h2D, 1'b1},
      '{8'h96, 2, 3'd4, 8'hE5, 1'b1},
      '{8'h96, 1, 3'd2, 8'h4B, 1'b0},
      '{8'h96, 4, 3'd3, 8'h60, 1'b1},
      '{8'hA5, 0, 3'd0, 8'hA5, 1'b0},
      '{8'hA5, 0, 3'd1, 8'hA5, 1'b0},
      '{8'hA5, 0, 3'd2, 8'hA5, 1'b0},
      '{8'hA5, 0, 3'd3, 8'hA5, 1'b0},
      '{8'hA5, 0, 3'd4, 8'hA5, 1'b0},
      '{8'hA5, 3, 3'd7, 8'hA5, 1'b0},
      '{8'hA5, 5, 3'd5, 8'hA5, 1'b0},
      '{8'hA5, 6, 3'd6, 8'hA5, 1'b0}
    };

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_carry", 32'(out_carry), 32'd0);

    // Directed vectors; the first one also measures latency on an empty pipeline.
    for (int i = 0; i < 13; i++) begin
      logic ec;
`ifdef BSH_CARRY_EN
      ec = dir[i].c;
`else
      ec = 1'b0;
`endif
      send_word(dir[i].a, dir[i].k, dir[i].m, TAG_W'(i), dir[i].y, ec, 1'b1);
      if (i == 0) begin
        idle();
        lat = 1;
        while (!out_valid && lat < 20) begin
          @(negedge clk);
          if (!out_valid) lat++;
        end
        @(negedge clk);
        chk("latency", 32'(lat), 32'(LOG2W));
      end
    end
    idle();
    drain();

    // Random stream with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) send_rand(TAG_W'(i), 1'b1);
    idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Full stall: exactly LOG2W words fit, then gapless drain.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc = 0;
    begin
      logic [W-1:0] a, y;
      int           k;
      logic [2:0]   m;
      logic         c;
      a = W'($urandom); k = int'($urandom_range(0, W - 1)); m = 3'($urandom_range(0, 4));
      ref_model(a, k, m, y, c);
      for (int cyc = 0; cyc < 10; cyc++) begin
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = a; in_amt = LOG2W'(k); in_mode = m; in_tag = TAG_W'(acc);
        @(negedge clk);
        if (in_ready) begin
          sb.push_back('{d: y, t: TAG_W'(acc), c: c});
          acc++;
          a = W'($urandom); k = int'($urandom_range(0, W - 1)); m = 3'($urandom_range(0, 4));
          ref_model(a, k, m, y, c);
        end
      end
    end
    chk("stall_accepted", 32'(acc), 32'(LOG2W));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int j = 0; j < LOG2W; j++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("release_gapless", 32'(cnt), 32'(LOG2W));
    @(negedge clk);
    chk("release_empty", 32'(out_valid), 32'd0);
    drain();

    // Reset with words in flight: none may ever appear.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(TAG_W'(i + 8), 1'b0);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    send_rand(TAG_W'(5), 1'b1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
